// File: rtl/cam_window_capture_if.sv
// rtl/cam_window_capture_if.sv - Avalon-ST style video stream bundle for cam_window_capture
// Ports (via modports):
//   master: drives st_data, st_valid, st_sop, st_eop; receives st_ready
//   slave : receives st_data, st_valid, st_sop, st_eop; drives st_ready
interface cam_window_capture_if #(
    parameter int DATA_W = 12
) ();
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (output st_data, output st_valid, output st_sop, output st_eop, input st_ready);
    modport slave  (input st_data, input st_valid, input st_sop, input st_eop, output st_ready);
endinterface

// File: rtl/cam_window_capture.sv
// rtl/cam_window_capture.sv - raw camera stream window crop with Avalon-ST output FIFO
// Ports:
//   clk_clk, reset_reset              : clock, asynchronous active-high reset
//   cam_d/fval/lval/pix_en            : raw sensor stream (already in clk_clk domain)
//   cfg_enable/x_start/y_start/width/height : window config, latched at frame start
//   st (master modport)               : cropped pixel stream with sop/eop
//   frame_count                       : completed (EOP-written) frames, wraps
//   overflow, overflow_clr            : sticky FIFO overflow flag and its clear
//   busy                              : high while a frame is being captured
module cam_window_capture #(
    parameter int DATA_W     = 12,
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [DATA_W-1:0]     cam_d,
    input  logic                  cam_fval,
    input  logic                  cam_lval,
    input  logic                  cam_pix_en,
    input  logic                  cfg_enable,
    input  logic [CNT_W-1:0]      cfg_x_start,
    input  logic [CNT_W-1:0]      cfg_y_start,
    input  logic [CNT_W-1:0]      cfg_width,
    input  logic [CNT_W-1:0]      cfg_height,
    cam_window_capture_if.master  st,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   END_ONE  = (CNT_W+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SKIP} state_t;

    // Input stage. fval/lval and their delayed copies reset high so that a
    // reset released mid-frame or mid-line never looks like a rising edge.
    logic [DATA_W-1:0] d_q;
    logic fval_q, lval_q, pen_q, fval_dly_q, lval_dly_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            d_q        <= '0;
            fval_q     <= 1'b1;
            lval_q     <= 1'b1;
            pen_q      <= 1'b0;
            fval_dly_q <= 1'b1;
            lval_dly_q <= 1'b1;
        end else begin
            d_q        <= cam_d;
            fval_q     <= cam_fval;
            lval_q     <= cam_lval;
            pen_q      <= cam_pix_en;
            fval_dly_q <= fval_q;
            lval_dly_q <= lval_q;
        end
    end

    logic fval_rise, fval_fall, lval_rise, lval_fall, qual, cfg_ok;
    assign fval_rise = fval_q & ~fval_dly_q;
    assign fval_fall = ~fval_q & fval_dly_q;
    assign lval_rise = lval_q & ~lval_dly_q;
    assign lval_fall = ~lval_q & lval_dly_q;
    assign qual      = fval_q & lval_q & pen_q;
    assign cfg_ok    = cfg_enable & (|cfg_width) & (|cfg_height);

    state_t state_q;
    logic   busy_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fval_rise) begin
                        state_q <= cfg_ok ? S_ARMED : S_SKIP;
                        busy_q  <= cfg_ok;
                    end
                end
                default: begin
                    if (fval_fall) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic [CNT_W-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q, col_q, row_q;
    logic [CNT_W-1:0] sh_x_d, sh_y_d, sh_w_d, sh_h_d, col_d, row_d;
    logic [CNT_W-1:0] col_cur, row_cur;
    logic [CNT_W:0]   x_end, y_end;
    logic             drop_q, drop_d, drop_cur, overflow_q, overflow_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      mcnt_q, mcnt_d, occ;
    logic             out_valid_q, out_valid_d;
    logic [WW-1:0]    out_word_q, out_word_d, wr_word;
    logic             armed_cur, in_win, sop, eop, want, full, pop, wr_ok, ovf_evt, load;
    logic [WW-1:0]    mem_q [FIFO_DEPTH];

    always_comb begin
        // At the FVAL rising edge the fresh config / row reset already apply
        // to that same cycle, so a pixel coinciding with the edge is handled.
        sh_x_d    = fval_rise ? cfg_x_start : sh_x_q;
        sh_y_d    = fval_rise ? cfg_y_start : sh_y_q;
        sh_w_d    = fval_rise ? cfg_width   : sh_w_q;
        sh_h_d    = fval_rise ? cfg_height  : sh_h_q;
        armed_cur = (state_q == S_IDLE) ? (fval_rise & cfg_ok) : (state_q == S_ARMED);
        drop_cur  = fval_rise ? 1'b0 : drop_q;

        col_cur = lval_rise ? '0 : col_q;
        row_cur = fval_rise ? '0 : row_q;
        col_d   = (qual && col_cur != '1) ? col_cur + CNT_ONE : col_cur;
        row_d   = (lval_fall && fval_q && row_cur != '1) ? row_cur + CNT_ONE : row_cur;

        // Window ends at CNT_W+1 bits: a window hanging past the counter
        // range simply never reaches its end column/row.
        x_end  = {1'b0, sh_x_d} + {1'b0, sh_w_d};
        y_end  = {1'b0, sh_y_d} + {1'b0, sh_h_d};
        in_win = (col_cur >= sh_x_d) && ({1'b0, col_cur} < x_end) &&
                 (row_cur >= sh_y_d) && ({1'b0, row_cur} < y_end);
        sop    = (col_cur == sh_x_d) && (row_cur == sh_y_d);
        eop    = ({1'b0, col_cur} == x_end - END_ONE) && ({1'b0, row_cur} == y_end - END_ONE);
        want   = armed_cur & qual & in_win & ~drop_cur;
        wr_word = {sop, eop, d_q};

        // Occupancy includes the output register, so FIFO_DEPTH is the total
        // number of words held. A pop in the same cycle frees the slot.
        occ     = mcnt_q + (out_valid_q ? OCC_ONE : '0);
        full    = (occ == OCC_FULL);
        pop     = out_valid_q & st.st_ready;
        wr_ok   = want & (~full | pop);
        ovf_evt = want & full & ~pop;
        load    = (~out_valid_q | pop) & (mcnt_q != '0);

        wptr_d = wr_ok ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = load  ? rptr_q + PTR_ONE : rptr_q;
        case ({wr_ok, load})
            2'b10:   mcnt_d = mcnt_q + OCC_ONE;
            2'b01:   mcnt_d = mcnt_q - OCC_ONE;
            default: mcnt_d = mcnt_q;
        endcase
        out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
        out_word_d  = load ? mem_q[rptr_q] : out_word_q;

        drop_d      = ovf_evt | drop_cur;
        overflow_d  = ovf_evt | (overflow_q & ~overflow_clr);
        frame_cnt_d = (wr_ok & eop) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_w_q      <= '0;
            sh_h_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            drop_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_w_q      <= sh_w_d;
            sh_h_q      <= sh_h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mcnt_q      <= mcnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_ok) mem_q[wptr_q] <= wr_word;
    end

    assign st.st_data   = out_word_q[DATA_W-1:0];
    assign st.st_eop    = out_word_q[DATA_W];
    assign st.st_sop    = out_word_q[DATA_W+1];
    assign st.st_valid  = out_valid_q;
    assign frame_count  = frame_cnt_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;
endmodule
